// File: rtl/multi_ff_bank.sv
// Bank of WIDTH flip-flop channels sharing one mode select (SR/JK/D/T),
// with sticky per-channel illegal-SR flags and a saturating illegal-cycle counter.
module multi_ff_bank #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             En,
  input  logic [1:0]       Mode,
  input  logic [WIDTH-1:0] S,
  input  logic [WIDTH-1:0] R,
  input  logic             ErrClr,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qn,
  output logic [WIDTH-1:0] Err,
  output logic [CNT_W-1:0] ErrCnt
);

  localparam logic [1:0] MODE_SR = 2'b00;
  localparam logic [1:0] MODE_JK = 2'b01;
  localparam logic [1:0] MODE_D  = 2'b10;
  localparam logic [1:0] MODE_T  = 2'b11;

  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] ill;
  logic             any_ill;

  always_comb begin
    ill     = (En && (Mode == MODE_SR)) ? (S & R) : '0;
    any_ill = |ill;

    q_d = q_q;
    if (En) begin
      case (Mode)
        // S^R==0 covers both hold (00) and the illegal hold (11)
        MODE_SR: q_d = (S & ~R) | (q_q & ~(S ^ R));
        MODE_JK: q_d = (S & ~q_q) | (~R & q_q);
        MODE_D:  q_d = S;
        MODE_T:  q_d = q_q ^ S;
        default: q_d = q_q;
      endcase
    end

    // A clear coinciding with a new illegal event keeps that event
    if (ErrClr) begin
      err_d = ill;
      cnt_d = any_ill ? CNT_W'(1) : '0;
    end else begin
      err_d = err_q | ill;
      cnt_d = cnt_q;
      if (any_ill && (cnt_q != '1)) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      q_q   <= '0;
      err_q <= '0;
      cnt_q <= '0;
    end else begin
      q_q   <= q_d;
      err_q <= err_d;
      cnt_q <= cnt_d;
    end
  end

  assign Q      = q_q;
  assign Qn     = ~q_q;
  assign Err    = err_q;
  assign ErrCnt = cnt_q;

endmodule

// File: tb/tb_multi_ff_bank.sv
// Self-checking bench for multi_ff_bank: directed vector table, hand sequences
// and randomized traffic, all compared against a per-channel behavioural model.
module tb_multi_ff_bank;

  logic       Clk;
  logic       Reset;
  logic       En;
  logic [1:0] Mode;
  logic [7:0] S;
  logic [7:0] R;
  logic       ErrClr;
  logic [7:0] Q, Qn, Err, ErrCnt;
  logic [7:0] Q2, Qn2, Err2;
  logic [1:0] ErrCnt2;

  int checks = 0;
  int errors = 0;

  multi_ff_bank #(.WIDTH(8), .CNT_W(8)) u_dut (
    .Clk(Clk), .Reset(Reset), .En(En), .Mode(Mode), .S(S), .R(R),
    .ErrClr(ErrClr), .Q(Q), .Qn(Qn), .Err(Err), .ErrCnt(ErrCnt)
  );

  // Same stimulus, narrow counter to exercise saturation quickly
  multi_ff_bank #(.WIDTH(8), .CNT_W(2)) u_sat (
    .Clk(Clk), .Reset(Reset), .En(En), .Mode(Mode), .S(S), .R(R),
    .ErrClr(ErrClr), .Q(Q2), .Qn(Qn2), .Err(Err2), .ErrCnt(ErrCnt2)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic [7:0] m_q, m_err;
  int         m_cnt8, m_cnt2;

  task automatic model_step(input logic rst, input logic en, input logic [1:0] mode,
                            input logic [7:0] s, input logic [7:0] r, input logic clr);
    logic [7:0] ill;
    ill = 8'h00;
    if (rst) begin
      m_q = 8'h00; m_err = 8'h00; m_cnt8 = 0; m_cnt2 = 0;
      return;
    end
    if (en) begin
      for (int i = 0; i < 8; i++) begin
        case (mode)
          2'd0: begin
            if (s[i] && !r[i]) m_q[i] = 1'b1;
            else if (!s[i] && r[i]) m_q[i] = 1'b0;
            else if (s[i] && r[i]) ill[i] = 1'b1;
          end
          2'd1: begin
            if (s[i] && r[i]) m_q[i] = !m_q[i];
            else if (s[i]) m_q[i] = 1'b1;
            else if (r[i]) m_q[i] = 1'b0;
          end
          2'd2: m_q[i] = s[i];
          default: m_q[i] = m_q[i] ^ s[i];
        endcase
      end
    end
    if (clr) begin
      m_err  = ill;
      m_cnt8 = (ill != 0) ? 1 : 0;
      m_cnt2 = m_cnt8;
    end else begin
      m_err = m_err | ill;
      if (ill != 0) begin
        m_cnt8 = (m_cnt8 + 1 > 255) ? 255 : m_cnt8 + 1;
        m_cnt2 = (m_cnt2 + 1 > 3) ? 3 : m_cnt2 + 1;
      end
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, "_q"},    {24'd0, Q},       {24'd0, m_q});
    chk({tag, "_qn"},   {24'd0, Qn},      {24'd0, ~m_q});
    chk({tag, "_err"},  {24'd0, Err},     {24'd0, m_err});
    chk({tag, "_cnt"},  {24'd0, ErrCnt},  m_cnt8);
    chk({tag, "_q2"},   {24'd0, Q2},      {24'd0, m_q});
    chk({tag, "_cnt2"}, {30'd0, ErrCnt2}, m_cnt2);
  endtask

  task automatic drive(input logic rst, input logic en, input logic [1:0] mode,
                       input logic [7:0] s, input logic [7:0] r, input logic clr);
    Reset = rst; En = en; Mode = mode; S = s; R = r; ErrClr = clr;
    @(posedge Clk);
    model_step(rst, en, mode, s, r, clr);
    #1;
  endtask

  typedef struct {
    logic       rst;
    logic       en;
    logic [1:0] mode;
    logic [7:0] s;
    logic [7:0] r;
    logic       clr;
    logic [7:0] eq;
    logic [7:0] eerr;
    logic [7:0] ecnt;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic rst, input logic en, input logic [1:0] mode,
                     input logic [7:0] s, input logic [7:0] r, input logic clr,
                     input logic [7:0] eq, input logic [7:0] eerr, input logic [7:0] ecnt);
    vec_t v;
    v.rst = rst; v.en = en; v.mode = mode; v.s = s; v.r = r; v.clr = clr;
    v.eq = eq; v.eerr = eerr; v.ecnt = ecnt;
    tbl.push_back(v);
  endtask

  initial begin
    Reset = 1'b1; En = 1'b0; Mode = 2'b00; S = 8'h00; R = 8'h00; ErrClr = 1'b0;
    m_q = 8'h00; m_err = 8'h00; m_cnt8 = 0; m_cnt2 = 0;

    //   rst en mode  S      R      clr  Q      Err    Cnt
    add(1, 1, 2'd2, 8'hFF, 8'h00, 0, 8'h00, 8'h00, 8'd0);
    add(0, 1, 2'd0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 8'd0);
    add(0, 1, 2'd0, 8'hFF, 8'h00, 0, 8'hFF, 8'h00, 8'd0);
    add(0, 1, 2'd0, 8'h00, 8'h0F, 0, 8'hF0, 8'h00, 8'd0);
    add(0, 1, 2'd0, 8'h00, 8'h00, 0, 8'hF0, 8'h00, 8'd0);
    add(0, 1, 2'd0, 8'h81, 8'h81, 0, 8'hF0, 8'h81, 8'd1);
    add(0, 1, 2'd0, 8'h81, 8'h81, 0, 8'hF0, 8'h81, 8'd2);
    add(0, 1, 2'd0, 8'h81, 8'h81, 0, 8'hF0, 8'h81, 8'd3);
    add(0, 1, 2'd0, 8'h00, 8'h00, 1, 8'hF0, 8'h00, 8'd0);
    add(0, 1, 2'd0, 8'h01, 8'h01, 1, 8'hF0, 8'h01, 8'd1);
    add(0, 1, 2'd0, 8'h81, 8'h81, 0, 8'hF0, 8'h81, 8'd2);
    add(1, 1, 2'd0, 8'hFF, 8'hFF, 1, 8'h00, 8'h00, 8'd0);
    add(0, 1, 2'd1, 8'hFF, 8'hFF, 0, 8'hFF, 8'h00, 8'd0);
    add(0, 1, 2'd1, 8'hFF, 8'hFF, 0, 8'h00, 8'h00, 8'd0);
    add(0, 1, 2'd3, 8'h0F, 8'h00, 0, 8'h0F, 8'h00, 8'd0);
    add(0, 0, 2'd3, 8'hFF, 8'h00, 0, 8'h0F, 8'h00, 8'd0);
    add(0, 1, 2'd0, 8'h10, 8'h10, 0, 8'h0F, 8'h10, 8'd1);
    add(0, 0, 2'd0, 8'hFF, 8'hFF, 1, 8'h0F, 8'h00, 8'd0);
    add(0, 1, 2'd2, 8'hA5, 8'hFF, 0, 8'hA5, 8'h00, 8'd0);
    add(0, 1, 2'd3, 8'hFF, 8'h00, 1, 8'h5A, 8'h00, 8'd0);

    foreach (tbl[k]) begin
      drive(tbl[k].rst, tbl[k].en, tbl[k].mode, tbl[k].s, tbl[k].r, tbl[k].clr);
      chk($sformatf("vec%0d_q", k),   {24'd0, Q},      {24'd0, tbl[k].eq});
      chk($sformatf("vec%0d_qn", k),  {24'd0, Qn},     {24'd0, ~tbl[k].eq});
      chk($sformatf("vec%0d_err", k), {24'd0, Err},    {24'd0, tbl[k].eerr});
      chk($sformatf("vec%0d_cnt", k), {24'd0, ErrCnt}, {24'd0, tbl[k].ecnt});
      chk_model($sformatf("vec%0d_m", k));
    end

    // Narrow counter saturates at 3 and never wraps
    drive(1, 0, 2'd0, 8'h00, 8'h00, 0);
    for (int k = 0; k < 5; k++) begin
      drive(0, 1, 2'd0, 8'h01, 8'h01, 0);
      chk($sformatf("sat2_%0d", k), {30'd0, ErrCnt2}, (k < 3) ? k + 1 : 3);
      chk_model($sformatf("sat_m%0d", k));
    end

    // Wide counter saturates at 255
    for (int k = 0; k < 260; k++) drive(0, 1, 2'd0, 8'hFF, 8'hFF, 0);
    chk("sat8_cnt", {24'd0, ErrCnt}, 32'd255);
    chk_model("sat8_m");

    drive(1, 0, 2'd0, 8'h00, 8'h00, 0);
    chk_model("rst2");
    for (int k = 0; k < 400; k++) begin
      logic       rr, ee, cc;
      logic [1:0] mm;
      logic [7:0] ss, qq;
      rr = ($urandom_range(0, 31) == 0);
      ee = ($urandom_range(0, 3) != 0);
      cc = ($urandom_range(0, 7) == 0);
      mm = 2'($urandom_range(0, 3));
      ss = 8'($urandom);
      qq = 8'($urandom);
      drive(rr, ee, mm, ss, qq, cc);
      chk_model($sformatf("rnd%0d", k));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multi_ff_bank.md
MULTI_FF_BANK -- requirements
Module: multi_ff_bank

Interface
REQ-001 Parameter WIDTH, default 8: number of independent flip-flop channels.
REQ-002 Parameter CNT_W, default 8: width of the illegal-event counter.
REQ-003 Clk  input  1: single clock; all state updates on rising edge.
REQ-004 Reset  input  1: synchronous, active-high reset; sampled on rising Clk.
REQ-005 En  input  1: when 1, channels update this edge; when 0, all channels hold.
REQ-006 Mode  input  2: channel behaviour. 00 = SR, 01 = JK, 10 = D, 11 = T. Applies to all channels.
REQ-007 S  input  WIDTH: per-channel set / J / D / T input.
REQ-008 R  input  WIDTH: per-channel reset / K input; ignored in D and T modes.
REQ-009 ErrClr  input  1: clears sticky error state.
REQ-010 Q  output  WIDTH: registered channel state.
REQ-011 Qn  output  WIDTH: bitwise inverse of Q, combinational from Q.
REQ-012 Err  output  WIDTH: sticky per-channel illegal-input flags, registered.
REQ-013 ErrCnt  output  CNT_W: saturating count of illegal cycles, registered.

Function
REQ-014 Mode, S, R and En are sampled on the same rising edge that updates Q; latency from input to Q is one cycle.
REQ-015 SR mode, per channel i: S=1,R=0 -> Q[i]=1; S=0,R=1 -> Q[i]=0; S=0,R=0 -> hold; S=1,R=1 -> hold and flag illegal.
REQ-016 JK mode, per channel: 10 -> 1; 01 -> 0; 00 -> hold; 11 -> Q[i] toggles. No illegal flag.
REQ-017 D mode: Q[i] <= S[i]. R ignored.
REQ-018 T mode: Q[i] <= Q[i] XOR S[i]. R ignored.
REQ-019 Illegal detection applies only when En=1 and Mode=00. It is per channel: ill[i] = S[i] AND R[i].
REQ-020 Err[i] is set on any edge where ill[i]=1. It stays set until ErrClr or Reset.
REQ-021 ErrCnt increments by exactly 1 per edge where any ill[i]=1, regardless of how many channels are illegal.
REQ-022 ErrCnt saturates at 2^CNT_W-1 and never wraps.
REQ-023 ErrClr=1 with no illegal condition on that edge -> Err=0 and ErrCnt=0 next cycle.
REQ-024 ErrClr=1 with a simultaneous illegal condition -> Err=ill and ErrCnt=1 next cycle.
  - The new event survives the clear.
REQ-025 ErrClr does not affect Q.
REQ-026 En=0 -> Q, Err and ErrCnt hold; ErrClr still acts.
REQ-027 A Mode change takes effect on the edge where the new value is sampled. There is no pipeline flush or extra cycle.
REQ-028 Qn == ~Q at all times, including during and after reset.

Reset
REQ-029 Reset=1 at a rising edge -> Q=0, Qn=all ones, Err=0, ErrCnt=0 next cycle.
REQ-030 Reset has priority over En, ErrClr and all data inputs, including mid-sequence and during illegal conditions.
REQ-031 Output values before the first reset edge are undefined. The bench applies Reset for at least 1 cycle at start.

Verification
REQ-032 Reset: WIDTH=8, Reset=1 for one edge with S=FF, R=00, Mode=10 -> Q=00, Qn=FF, Err=00, ErrCnt=0.
REQ-033 SR table: Mode=00, En=1.
  - S/R pairs 00/00, FF/00, 00/0F, 00/00 on successive edges -> Q=00, FF, F0, F0.
  - Err=00 throughout.
REQ-034 SR illegal: Q=F0, S=81, R=81 for 3 edges -> Q=F0, Err=81, ErrCnt=3.
  - Next edge with ErrClr=1 and S=R=00 -> Err=00, ErrCnt=0.
  - Next edge with ErrClr=1 and S=R=01 -> Err=01, ErrCnt=1.
REQ-035 JK/T: Mode=01, Q=00.
  - S=R=FF for 2 edges -> Q=FF then 00.
  - Then Mode=11, S=0F for 1 edge -> Q=0F.
  - Then En=0, S=FF -> Q stays 0F.
REQ-036 Saturation: CNT_W=2, Mode=00, S=R=01 for 5 edges -> ErrCnt=1,2,3,3,3.
REQ-037 Reset mid-operation: during REQ-034 with ErrCnt=2, assert Reset together with S=R=FF -> Q=00, Err=00, ErrCnt=0.
